// File: rtl/skew_pkg.sv
// rtl/skew_pkg.sv - shared mode type and per-lane delay rule for the skew buffer
//
// Purpose: holds the SKEW/DESKEW mode enum and delay_of(), which gives the
// delay of lane k in an n-lane buffer for a given mode.
// Ports: none (package).

package skew_pkg;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } mode_e;

  // SKEW staggers lanes so lane k trails lane 0 by k cycles; DESKEW is the
  // mirror image and realigns a previously skewed column.
  function automatic int delay_of(input int k, input int n, input mode_e mode);
    return (mode == SKEW) ? k : (n - 1 - k);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one activation lane: register chain, valid bits, mode tap
//
// Purpose: delays one lane by delay_of(LANE, DEPTH+1, mode) accepted cycles.
// The full DEPTH-stage chain is always built so either mode's tap is present.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             advance strobe; 0 holds every register
//   mode           active mode, selects the output tap
//   act_valid_i    input sample valid
//   act_i          input sample
//   act_o          delayed sample (zero for bubbles)
//   act_valid_o    valid travelling with act_o

module skew_lane
  import skew_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 15,
  parameter int LANE      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  mode_e                mode,
  input  logic                 act_valid_i,
  input  logic [DATAWIDTH-1:0] act_i,
  output logic [DATAWIDTH-1:0] act_o,
  output logic                 act_valid_o
);

  localparam int D_SKEW   = delay_of(LANE, DEPTH + 1, SKEW);
  localparam int D_DESKEW = delay_of(LANE, DEPTH + 1, DESKEW);

  logic [DEPTH-1:0][DATAWIDTH-1:0] data_q;
  logic [DEPTH-1:0]                vld_q;
  logic [DATAWIDTH-1:0]            fill_data;

  // Bubbles are stored as zero so an idle pipe never leaks stale data.
  assign fill_data = act_valid_i ? act_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else if (en) begin
      data_q[0] <= fill_data;
      vld_q[0]  <= act_valid_i;
      for (int j = 1; j < DEPTH; j++) begin
        data_q[j] <= data_q[j-1];
        vld_q[j]  <= vld_q[j-1];
      end
    end
  end

  logic [DATAWIDTH-1:0] skew_data;
  logic [DATAWIDTH-1:0] deskew_data;
  logic                 skew_vld;
  logic                 deskew_vld;

  // A zero-delay tap bypasses the chain entirely; its valid is qualified by
  // en because a stalled cycle accepts nothing.
  if (D_SKEW == 0) begin : g_skew_comb
    assign skew_data = fill_data;
    assign skew_vld  = act_valid_i & en;
  end else begin : g_skew_reg
    assign skew_data = data_q[D_SKEW-1];
    assign skew_vld  = vld_q[D_SKEW-1];
  end

  if (D_DESKEW == 0) begin : g_deskew_comb
    assign deskew_data = fill_data;
    assign deskew_vld  = act_valid_i & en;
  end else begin : g_deskew_reg
    assign deskew_data = data_q[D_DESKEW-1];
    assign deskew_vld  = vld_q[D_DESKEW-1];
  end

  assign act_o       = (mode == SKEW) ? skew_data : deskew_data;
  assign act_valid_o = (mode == SKEW) ? skew_vld  : deskew_vld;

  // Middle lanes never tap the last stage in either mode; the stage is kept
  // so every lane has identical structure.
  logic unused_tail;
  assign unused_tail = ^{vld_q[DEPTH-1], data_q[DEPTH-1]};

endmodule

// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - systolic-array activation skew/deskew buffer
//
// Purpose: delays each of N_SIZE lanes by its lane-dependent amount, tracks
// in-flight data with a drain counter and only allows mode switches when idle.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             advance strobe; 0 stalls everything
//   mode_i         requested mode (0 SKEW, 1 DESKEW)
//   act_valid_i    input column valid
//   act_i          input column, one DATAWIDTH word per lane
//   act_o          delayed column
//   act_valid_o    per-lane valid
//   mode_o         active mode
//   busy_o         valid data still in flight
//   mode_err_o     one-cycle pulse per rejected mode change

module skew_buffer
  import skew_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             mode_i,
  input  logic                             act_valid_i,
  input  logic [N_SIZE-1:0][DATAWIDTH-1:0] act_i,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0] act_o,
  output logic [N_SIZE-1:0]                act_valid_o,
  output logic                             mode_o,
  output logic                             busy_o,
  output logic                             mode_err_o
);

  localparam int DEPTH = N_SIZE - 1;
  localparam int CW    = $clog2(N_SIZE);

  mode_e           mode_q;
  mode_e           mode_req;
  logic [CW-1:0]   drain_q;
  logic            err_q;
  logic            busy;

  assign mode_req = mode_e'(mode_i);
  assign busy     = (drain_q != '0);

  // The longest lane delay is N_SIZE-1 accepted cycles, so reloading to that
  // value on every valid sample covers the slowest lane. Load beats decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q <= '0;
      mode_q  <= SKEW;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (en && act_valid_i) begin
        drain_q <= CW'(N_SIZE - 1);
      end else if (en && busy) begin
        drain_q <= drain_q - 1'b1;
      end
      // Switching taps with data in flight would scramble it, and a valid
      // input always wins over a mode change on the same edge.
      if (mode_req != mode_q) begin
        if (busy || act_valid_i) begin
          err_q <= 1'b1;
        end else begin
          mode_q <= mode_req;
        end
      end
    end
  end

  for (genvar k = 0; k < N_SIZE; k++) begin : g_lane
    skew_lane #(
      .DATAWIDTH(DATAWIDTH),
      .DEPTH    (DEPTH),
      .LANE     (k)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode_q),
      .act_valid_i(act_valid_i),
      .act_i      (act_i[k]),
      .act_o      (act_o[k]),
      .act_valid_o(act_valid_o[k])
    );
  end

  assign mode_o     = mode_q;
  assign busy_o     = busy;
  assign mode_err_o = err_q;

endmodule

// File: tb/tb_skew_buffer.sv
// tb/tb_skew_buffer.sv - self-checking bench for skew_buffer (N_SIZE=4, DATAWIDTH=8)

module tb_skew_buffer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 mode_i;
  logic                 act_valid_i;
  logic [N-1:0][DW-1:0] act_i;
  logic [N-1:0][DW-1:0] act_o;
  logic [N-1:0]         act_valid_o;
  logic                 mode_o;
  logic                 busy_o;
  logic                 mode_err_o;

  always #5 clk = ~clk;

  skew_buffer #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode_i     (mode_i),
    .act_valid_i(act_valid_i),
    .act_i      (act_i),
    .act_o      (act_o),
    .act_valid_o(act_valid_o),
    .mode_o     (mode_o),
    .busy_o     (busy_o),
    .mode_err_o (mode_err_o)
  );

  // Reference: history of the last N-1 accepted columns (index 0 = newest).
  logic [N*DW-1:0] hd [0:N-2];
  logic            hv [0:N-2];
  logic            m_mode;
  logic            m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    for (int i = 0; i < N - 1; i++) begin
      hd[i] = '0;
      hv[i] = 1'b0;
    end
    m_mode = 1'b0;
    m_err  = 1'b0;
  endtask

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < N - 1; i++) b = b | hv[i];
    return b;
  endfunction

  task automatic model_edge();
    logic b;
    logic nerr;
    b    = model_busy();
    nerr = 1'b0;
    if (mode_i != m_mode) begin
      if (b || act_valid_i) nerr = 1'b1;
      else m_mode = mode_i;
    end
    if (en) begin
      for (int i = N - 2; i > 0; i--) begin
        hd[i] = hd[i-1];
        hv[i] = hv[i-1];
      end
      hd[0] = act_valid_i ? act_i : '0;
      hv[0] = act_valid_i;
    end
    m_err = nerr;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
  endtask

  task automatic check_all();
    logic [N*DW-1:0] e_d;
    logic [N-1:0]    e_v;
    int d;
    for (int k = 0; k < N; k++) begin
      d = (m_mode == 1'b0) ? k : (N - 1 - k);
      if (d == 0) begin
        e_d[k*DW +: DW] = act_valid_i ? act_i[k] : '0;
        e_v[k]          = act_valid_i & en;
      end else begin
        e_d[k*DW +: DW] = hd[d-1][k*DW +: DW];
        e_v[k]          = hv[d-1];
      end
    end
    chk("act_o",       64'(act_o),       64'(e_d));
    chk("act_valid_o", 64'(act_valid_o), 64'(e_v));
    chk("mode_o",      64'(mode_o),      64'(m_mode));
    chk("busy_o",      64'(busy_o),      64'(model_busy()));
    chk("mode_err_o",  64'(mode_err_o),  64'(m_err));
  endtask

  task automatic cycle(input logic e, input logic v, input logic m, input logic [31:0] d);
    @(negedge clk);
    en          = e;
    act_valid_i = v;
    mode_i      = m;
    act_i       = d;
    #1 check_all();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    logic cur_mode;
    rst         = 1'b1;
    en          = 1'b0;
    mode_i      = 1'b0;
    act_valid_i = 1'b0;
    act_i       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    rst = 1'b0;

    // Single column in SKEW
    cycle(1, 1, 0, 32'h44332211);
    repeat (5) cycle(1, 0, 0, 32'h0);

    // Switch to DESKEW while idle, then single column
    cycle(1, 0, 1, 32'h0);
    cycle(1, 1, 1, 32'h44332211);
    repeat (5) cycle(1, 0, 1, 32'h0);
    cycle(1, 0, 0, 32'h0);

    // SKEW stream with a stall on the third column
    cycle(1, 1, 0, 32'hA3A2A1A0);
    cycle(1, 1, 0, 32'hB3B2B1B0);
    cycle(0, 1, 0, 32'hC3C2C1C0);
    cycle(1, 1, 0, 32'hC3C2C1C0);
    cycle(1, 1, 0, 32'hD3D2D1D0);
    cycle(0, 0, 0, 32'h0);
    repeat (5) cycle(1, 0, 0, 32'h0);

    // Mode change rejected while busy, accepted once drained
    cycle(1, 1, 0, 32'h0F0E0D0C);
    repeat (6) cycle(1, 0, 1, 32'h0);
    // Rejected because a valid input is present even when idle
    cycle(0, 1, 0, 32'h12345678);
    cycle(1, 0, 0, 32'h0);

    // Bubbles with all-ones data
    repeat (2) cycle(1, 0, 0, 32'hFFFFFFFF);

    // Asynchronous reset mid-stream
    cycle(1, 1, 0, 32'h55555555);
    cycle(1, 1, 0, 32'h66666666);
    @(negedge clk);
    en = 1'b1; act_valid_i = 1'b1; act_i = 32'h77777777;
    #1 check_all();
    #1;
    rst = 1'b1;
    act_valid_i = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    #1 check_all();
    rst = 1'b0;
    repeat (4) cycle(1, 0, 0, 32'h0);

    // Randomized traffic
    cur_mode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) cur_mode = ~cur_mode;
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
            cur_mode, 32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/skew_buffer.md
SKEW_BUFFER -- requirements
Module: skew_buffer

Interface
REQ-001 Parameter DATAWIDTH, default 8, bit width of each activation lane.
REQ-002 Parameter N_SIZE, default 16, lane count; legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  advance strobe; 0 = stall, all state holds.
REQ-006 mode_i  input  1  requested mode: 0 = SKEW, 1 = DESKEW.
REQ-007 act_valid_i  input  1  input column valid.
REQ-008 act_i  input  [DATAWIDTH-1:0] x N_SIZE  input activations, one per lane.
REQ-009 act_o  output  [DATAWIDTH-1:0] x N_SIZE  delayed activations.
REQ-010 act_valid_o  output  N_SIZE  per-lane valid travelling with the data.
REQ-011 mode_o  output  1  currently active mode.
REQ-012 busy_o  output  1  valid data is still in flight.
REQ-013 mode_err_o  output  1  one-cycle pulse when a mode change is rejected.

Function
REQ-014 Lane k delay d(k) SHALL be k in SKEW and N_SIZE-1-k in DESKEW, counted in en=1 cycles.
REQ-015 Lane with d(k)=0 SHALL be combinational: act_o[k] = act_valid_i ? act_i[k] : 0, and act_valid_o[k] = act_valid_i & en.
REQ-016 A lane with d(k)>0 SHALL present at its output, registered, the sample accepted d(k) en-cycles earlier.
REQ-017 A sample SHALL be accepted when en=1; if act_valid_i=0 the stored data SHALL be zero and the stored valid SHALL be 0 (zero-fill bubble).
REQ-018 When en=0, every register SHALL hold, and act_valid_o of registered lanes SHALL hold its value.
REQ-019 Each lane SHALL implement a chain of N_SIZE-1 registers with an output tap selected by mode_o, so that a mode change needs no reallocation.
REQ-020 The drain counter (width clog2(N_SIZE)) SHALL load N_SIZE-1 on an accepted valid sample; otherwise it SHALL decrement by 1 on en=1 while nonzero.
REQ-021 busy_o SHALL be 1 exactly when the drain counter is nonzero.
REQ-022 mode_o SHALL update to mode_i on an edge where mode_i != mode_o, busy_o=0, and act_valid_i=0.
REQ-023 If mode_i != mode_o while busy_o=1 or act_valid_i=1, mode_o SHALL hold and mode_err_o SHALL pulse high for one cycle per such edge.
REQ-024 A mode change and an accepted valid sample cannot occur on the same edge; a valid input always wins.
REQ-025 Simultaneous load and decrement of the drain counter SHALL resolve to load.

Reset
REQ-026 Reset SHALL clear all delay registers and per-lane valid registers, and set act_o = 0 for registered lanes and act_valid_o = 0.
REQ-027 Reset SHALL set mode_o = SKEW, the drain counter to 0, busy_o = 0, and mode_err_o = 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; no valid SHALL appear after release until new input is accepted.

Structure
REQ-029 Package skew_pkg SHALL hold the mode enum (SKEW, DESKEW) and a constant function delay_of(k, n, mode).
REQ-030 Sub-module skew_lane (parameters DATAWIDTH, DEPTH, and a lane index) SHALL implement one register chain, its valid bits, and the tap mux; skew_buffer instantiates N_SIZE copies via generate.
REQ-031 No lane count SHALL be hard-coded; all loop bounds derive from N_SIZE.

Verification (N_SIZE=4, DATAWIDTH=8)
REQ-032 SKEW, en=1, one valid column {0x11,0x22,0x33,0x44} at cycle 0 -> lane0 0x11 at cycle 0, lane1 0x22 at cycle 1, lane2 0x33 at cycle 2, lane3 0x44 at cycle 3, each with its valid bit; busy_o falls after cycle 3.
REQ-033 DESKEW, same column -> lane3 at cycle 0, lane2 at cycle 1, lane1 at cycle 2, lane0 at cycle 3.
REQ-034 SKEW stream of 4 columns with en=0 on cycle 2 -> every output lags by exactly one extra cycle from the stall onward; no data lost or duplicated.
REQ-035 mode_i toggled to DESKEW while busy_o=1 -> mode_err_o=1 for one cycle and mode_o stays SKEW; after the drain completes, mode_o becomes DESKEW on the next edge.
REQ-036 act_valid_i=0 with act_i=0xFF -> act_o=0 and act_valid_o=0 on all lanes.
REQ-037 rst asserted asynchronously at cycle 2 of a stream -> outputs and valids clear immediately; after release with no input, busy_o=0 and no valid appears.
